alu_control_pipe: RTL and testbench

Parametrised, registered ALU control stage for the segmented processor. It decodes ALUop plus the R-type funct field into contALU one cycle after acceptance, honours pipeline stall/flush, and sequences multi-cycle MULT/DIV operations with a start pulse and a busy/stall window. It sits between the ID/EX register and the ALU/multiplier-divider.

---
 rtl/alu_control_pipe.sv | 145 ++++++++++++++
 tb/tb_alu_control_pipe.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/alu_control_pipe.sv
// Registered ALU control decode with a MULT/DIV launch/busy sequencer and stall/flush handling.
// Optional build macro ALU_CTRL_ILLEGAL_TRAP_EN turns unrecognised R-type functs into an illegal trap.
module alu_control_pipe #(
  parameter int OP_W    = 2,
  parameter int FUNCT_W = 6,
  parameter int CTRL_W  = 4,
  parameter int MD_LAT  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic               stall_in,
  input  logic               flush_in,
  input  logic [OP_W-1:0]    ALUop,
  input  logic [FUNCT_W-1:0] instru,
  output logic [CTRL_W-1:0]  contALU,
  output logic               valid_out,
  output logic               md_start,
  output logic               md_busy,
  output logic               stall_out,
  output logic               illegal
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_MD_RUN = 1'b1;

  localparam int CNT_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 1);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_MULT = 4'b1000;
  localparam logic [3:0] C_DIV  = 4'b1001;
  localparam logic [3:0] C_NOR  = 4'b1100;
  localparam logic [3:0] C_TRAP = 4'b1111;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_code;
  logic             r_valid;
  logic             r_start;
  logic             r_busy;
  logic             r_illegal;

  logic [3:0] w_code;
  logic       w_valid;
  logic       w_is_md;
  logic       w_ill;

  // A case selector carrying X/Z matches no item, so such functs fall to default.
  always_comb begin
    w_code  = C_ADD;
    w_valid = 1'b1;
    w_is_md = 1'b0;
    w_ill   = 1'b0;
    case (ALUop[1:0])
      2'b00: w_code = C_ADD;
      2'b01: w_code = C_SUB;
      2'b11: w_code = C_OR;
      2'b10: begin
        case (instru[5:0])
          6'b100000: w_code = C_ADD;
          6'b100010: w_code = C_SUB;
          6'b100100: w_code = C_AND;
          6'b100101: w_code = C_OR;
          6'b101010: w_code = C_SLT;
          6'b100111: w_code = C_NOR;
          6'b011000: begin w_code = C_MULT; w_is_md = 1'b1; end
          6'b011010: begin w_code = C_DIV;  w_is_md = 1'b1; end
          default: begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            w_code  = C_TRAP;
            w_valid = 1'b0;
            w_ill   = 1'b1;
`else
            w_code  = C_ADD;
`endif
          end
        endcase
      end
      default: w_code = C_ADD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_code    <= '0;
      r_valid   <= 1'b0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (flush_in) begin
      // contALU deliberately keeps its last value across a flush
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (!stall_in) begin
      r_start   <= 1'b0;
      r_illegal <= 1'b0;
      if (r_state == S_IDLE) begin
        if (valid_in) begin
          r_code    <= w_code;
          r_valid   <= w_valid;
          r_illegal <= w_ill;
          if (w_is_md) begin
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= CNT_LOAD;
            r_state <= S_MD_RUN;
          end
        end else begin
          r_valid <= 1'b0;
        end
      end else begin
        r_valid <= 1'b0;
        if (r_cnt == '0) begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  always_comb begin
    contALU      = '0;
    contALU[3:0] = r_code;
  end

  assign valid_out = r_valid;
  assign md_start  = r_start;
  assign md_busy   = r_busy;
  assign stall_out = r_busy;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_control_pipe.sv
// Directed-vector bench: stimulus queues the hand-computed outputs expected after each edge,
// and a negedge monitor pops and compares them against the DUT.
module tb_alu_control_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic       stall_in;
  logic       flush_in;
  logic [1:0] ALUop;
  logic [5:0] instru;
  logic [3:0] contALU;
  logic       valid_out;
  logic       md_start;
  logic       md_busy;
  logic       stall_out;
  logic       illegal;

  int errors = 0;
  int checks = 0;

  // {contALU, valid_out, md_start, md_busy, stall_out, illegal}
  logic [8:0] exp_q[$];
  string      name_q[$];

  always #5 clk = ~clk;

  alu_control_pipe #(.OP_W(2), .FUNCT_W(6), .CTRL_W(4), .MD_LAT(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .stall_in(stall_in), .flush_in(flush_in),
    .ALUop(ALUop), .instru(instru), .contALU(contALU), .valid_out(valid_out),
    .md_start(md_start), .md_busy(md_busy), .stall_out(stall_out), .illegal(illegal)
  );

  // Drive one cycle of inputs and queue the outputs expected after the following edge.
  task automatic step(input logic r, input logic v, input logic s, input logic f,
                      input logic [1:0] op, input logic [5:0] fn,
                      input logic [3:0] e_ctrl, input logic e_v, input logic e_st,
                      input logic e_bz, input logic e_il, input string nm);
    rst = r; valid_in = v; stall_in = s; flush_in = f; ALUop = op; instru = fn;
    @(posedge clk);
    exp_q.push_back({e_ctrl, e_v, e_st, e_bz, e_bz, e_il});
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  initial begin : monitor
    logic [8:0] got;
    logic [8:0] e;
    string      nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        got = {contALU, valid_out, md_start, md_busy, stall_out, illegal};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL %s: got ctrl=%b v=%b st=%b bz=%b so=%b il=%b, expected ctrl=%b v=%b st=%b bz=%b so=%b il=%b",
                   nm, got[8:5], got[4], got[3], got[2], got[1], got[0],
                   e[8:5], e[4], e[3], e[2], e[1], e[0]);
        end else begin
          $display("ok   %s: ctrl=%b v=%b st=%b bz=%b il=%b", nm, got[8:5], got[4], got[3], got[2], got[0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; valid_in = 1'b0; stall_in = 1'b0; flush_in = 1'b0; ALUop = 2'b00; instru = 6'b0;
    @(negedge clk);

    // reset with a valid ADD presented
    step(1, 1, 0, 0, 2'b10, 6'b100000, 4'b0000, 0, 0, 0, 0, "rst0");
    step(1, 1, 0, 0, 2'b10, 6'b100000, 4'b0000, 0, 0, 0, 0, "rst1");
    step(0, 1, 0, 0, 2'b10, 6'b100000, 4'b0010, 1, 0, 0, 0, "post_rst_add");

    // back-to-back decode table
    step(0, 1, 0, 0, 2'b00, 6'b000000, 4'b0010, 1, 0, 0, 0, "op00_add");
    step(0, 1, 0, 0, 2'b01, 6'b000000, 4'b0110, 1, 0, 0, 0, "op01_sub");
    step(0, 1, 0, 0, 2'b10, 6'b100010, 4'b0110, 1, 0, 0, 0, "r_sub");
    step(0, 1, 0, 0, 2'b10, 6'b100100, 4'b0000, 1, 0, 0, 0, "r_and");
    step(0, 1, 0, 0, 2'b10, 6'b100101, 4'b0001, 1, 0, 0, 0, "r_or");
    step(0, 1, 0, 0, 2'b10, 6'b101010, 4'b0111, 1, 0, 0, 0, "r_slt");
    step(0, 1, 0, 0, 2'b10, 6'b100111, 4'b1100, 1, 0, 0, 0, "r_nor");
    step(0, 1, 0, 0, 2'b11, 6'b111111, 4'b0001, 1, 0, 0, 0, "op11_or");
    step(0, 0, 0, 0, 2'b00, 6'b000000, 4'b0001, 0, 0, 0, 0, "idle_hold");

    // MULT, busy for 4 cycles, ADD held upstream meanwhile
    step(0, 1, 0, 0, 2'b10, 6'b011000, 4'b1000, 1, 1, 1, 0, "mult_start");
    step(0, 1, 0, 0, 2'b10, 6'b100000, 4'b1000, 0, 0, 1, 0, "mult_busy2");
    step(0, 1, 0, 0, 2'b10, 6'b100000, 4'b1000, 0, 0, 1, 0, "mult_busy3");
    step(0, 1, 0, 0, 2'b10, 6'b100000, 4'b1000, 0, 0, 1, 0, "mult_busy4");
    step(0, 1, 0, 0, 2'b10, 6'b100000, 4'b1000, 0, 0, 0, 0, "mult_done");
    step(0, 1, 0, 0, 2'b10, 6'b100000, 4'b0010, 1, 0, 0, 0, "add_after_md");
    step(0, 0, 0, 0, 2'b00, 6'b000000, 4'b0010, 0, 0, 0, 0, "idle2");

    // MULT with 3-cycle stall: busy stretches to 7 cycles
    step(0, 1, 0, 0, 2'b10, 6'b011000, 4'b1000, 1, 1, 1, 0, "smult_start");
    step(0, 0, 0, 0, 2'b00, 6'b000000, 4'b1000, 0, 0, 1, 0, "smult_b2");
    step(0, 0, 1, 0, 2'b00, 6'b000000, 4'b1000, 0, 0, 1, 0, "smult_stall1");
    step(0, 0, 1, 0, 2'b00, 6'b000000, 4'b1000, 0, 0, 1, 0, "smult_stall2");
    step(0, 0, 1, 0, 2'b00, 6'b000000, 4'b1000, 0, 0, 1, 0, "smult_stall3");
    step(0, 0, 0, 0, 2'b00, 6'b000000, 4'b1000, 0, 0, 1, 0, "smult_b6");
    step(0, 0, 0, 0, 2'b00, 6'b000000, 4'b1000, 0, 0, 1, 0, "smult_b7");
    step(0, 0, 0, 0, 2'b00, 6'b000000, 4'b1000, 0, 0, 0, 0, "smult_done");

    // SUB held by stall while a new op is presented
    step(0, 1, 0, 0, 2'b01, 6'b000000, 4'b0110, 1, 0, 0, 0, "sub");
    step(0, 1, 1, 0, 2'b00, 6'b000000, 4'b0110, 1, 0, 0, 0, "sub_stall1");
    step(0, 1, 1, 0, 2'b00, 6'b000000, 4'b0110, 1, 0, 0, 0, "sub_stall2");
    step(0, 1, 1, 0, 2'b00, 6'b000000, 4'b0110, 1, 0, 0, 0, "sub_stall3");
    step(0, 0, 0, 0, 2'b00, 6'b000000, 4'b0110, 0, 0, 0, 0, "sub_release");

    // DIV flushed in its second busy cycle
    step(0, 1, 0, 0, 2'b10, 6'b011010, 4'b1001, 1, 1, 1, 0, "div_start");
    step(0, 0, 0, 0, 2'b00, 6'b000000, 4'b1001, 0, 0, 1, 0, "div_busy2");
    step(0, 0, 0, 1, 2'b00, 6'b000000, 4'b1001, 0, 0, 0, 0, "div_flush");
    step(0, 0, 0, 0, 2'b00, 6'b000000, 4'b1001, 0, 0, 0, 0, "div_idle");
    step(0, 1, 0, 0, 2'b00, 6'b000000, 4'b0010, 1, 0, 0, 0, "add_after_flush");
    step(0, 1, 1, 1, 2'b01, 6'b000000, 4'b0010, 0, 0, 0, 0, "flush_beats_stall");
    step(0, 1, 0, 0, 2'b01, 6'b000000, 4'b0110, 1, 0, 0, 0, "sub_after_flush");

    // unrecognised funct
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    step(0, 1, 0, 0, 2'b10, 6'b111111, 4'b1111, 0, 0, 0, 1, "illegal_trap");
    step(0, 0, 0, 0, 2'b00, 6'b000000, 4'b1111, 0, 0, 0, 0, "illegal_clear");
`else
    step(0, 1, 0, 0, 2'b10, 6'b111111, 4'b0010, 1, 0, 0, 0, "illegal_as_add");
    step(0, 0, 0, 0, 2'b00, 6'b000000, 4'b0010, 0, 0, 0, 0, "illegal_idle");
`endif

    // MULT with a stall on its start cycle keeps md_start high
    step(0, 1, 0, 0, 2'b10, 6'b011000, 4'b1000, 1, 1, 1, 0, "hstart");
    step(0, 0, 1, 0, 2'b00, 6'b000000, 4'b1000, 1, 1, 1, 0, "hstart_stall");
    step(0, 0, 0, 0, 2'b00, 6'b000000, 4'b1000, 0, 0, 1, 0, "hstart_b2");

    valid_in = 1'b0; stall_in = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
